// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: turns M-stage load/store controls into a held req/ack
// memory access, stalls the pipeline front and flags misaligned/timed-out accesses.
// Optional build macro: MEM_STAGE_CTRL_POSTED_STORE_EN (posted stores).
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_M,
  input  logic              write_enable_dmem_M,
  input  logic [1:0]        write_back_M,
  input  logic [DATA_W-1:0] alu_rsl_M,
  input  logic [DATA_W-1:0] wd_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata_M,
  output logic              stall_M,
  output logic              bubble_W,
  input  logic              err_clr,
  output logic              err_o,
  output logic [DATA_W-1:0] err_addr
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   err_addr_q;
  logic [CNT_W-1:0]    cnt_q;
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
  logic                posted_q;
`endif

  logic              access;
  logic              is_store;
  logic              misaligned;
  logic              timeout;
  logic              err_set;
  logic [DATA_W-1:0] err_set_addr;

  assign access     = valid_M & (write_enable_dmem_M | (write_back_M == 2'b01));
  assign is_store   = write_enable_dmem_M;
  assign misaligned = alu_rsl_M[1:0] != 2'b00;
  assign timeout    = (state_q == BUSY) & ~mem_ack & (cnt_q == CNT_LAST);

  always_comb begin
    err_set      = 1'b0;
    err_set_addr = '0;
    if ((state_q == IDLE) && access && misaligned) begin
      err_set      = 1'b1;
      err_set_addr = alu_rsl_M;
    end else if (timeout) begin
      err_set      = 1'b1;
      err_set_addr = mem_addr_q;
    end
  end

  always_comb begin
    stall_M  = 1'b0;
    bubble_W = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
          stall_M  = ~is_store;
          bubble_W = ~is_store;
`else
          stall_M  = 1'b1;
          bubble_W = 1'b1;
`endif
        end else if (access) begin
          bubble_W = 1'b1;
        end
      end
      BUSY: begin
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
        // A posted store only holds back the next memory instruction.
        stall_M  = posted_q ? access : 1'b1;
        bubble_W = posted_q ? access : 1'b1;
`else
        stall_M  = 1'b1;
        bubble_W = 1'b1;
`endif
      end
      default: begin
        stall_M  = 1'b0;
        bubble_W = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      cnt_q       <= '0;
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
      posted_q    <= 1'b0;
`endif
    end else begin
      // A simultaneous set overrides err_clr and captures the new address.
      if (err_set) begin
        err_q <= 1'b1;
        if (!err_q || err_clr) err_addr_q <= err_set_addr;
      end else if (err_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (access && !misaligned) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store;
            mem_addr_q  <= alu_rsl_M;
            mem_wdata_q <= wd_M;
            cnt_q       <= '0;
            state_q     <= BUSY;
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
            posted_q    <= is_store;
`endif
          end
        end
        BUSY: begin
          if (mem_ack || timeout) begin
            mem_req_q <= 1'b0;
            if (mem_ack && !mem_we_q) rdata_q <= mem_rdata;
`ifdef MEM_STAGE_CTRL_POSTED_STORE_EN
            state_q <= posted_q ? IDLE : DONE;
`else
            state_q <= DONE;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata_M   = rdata_q;
  assign err_o     = err_q;
  assign err_addr  = err_addr_q;

endmodule
